// File: rtl/dot8_sequencer.sv
// Dot-product sequencer: steps a shared select across upstream A/B element muxes,
// accumulates a_in*b_in over LENGTH pairs and hands off the result with valid/ready.
module dot8_sequencer #(
    parameter int unsigned LENGTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] sel,
    input  real        a_in,
    input  real        b_in,
    output real        acc_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] LAST = 3'(LENGTH - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] sel_d;
    real        acc_q, acc_d;
    real        acc_out_d;
    logic       out_valid_d;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel;
        acc_d       = acc_q;
        acc_out_d   = acc_out;
        out_valid_d = out_valid;
        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (start) begin
                    state_d = RUN;
                    acc_d   = 0.0;
                end
            end
            RUN: begin
                // a_in/b_in are only consumed here; the final product goes straight to acc_out.
                acc_d = acc_q + a_in * b_in;
                if (sel == LAST) begin
                    acc_out_d   = acc_d;
                    out_valid_d = 1'b1;
                    sel_d       = 3'd0;
                    state_d     = DONE;
                end else begin
                    sel_d = sel + 3'd1;
                end
            end
            DONE: begin
                sel_d = 3'd0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d = RUN;
                        acc_d   = 0.0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                sel_d       = 3'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel       <= 3'd0;
            acc_q     <= 0.0;
            acc_out   <= 0.0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel       <= sel_d;
            acc_q     <= acc_d;
            acc_out   <= acc_out_d;
            out_valid <= out_valid_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dot8_sequencer.sv
// Bench for dot8_sequencer: an 8-pair and a 3-pair instance fed from modelled
// upstream muxes, with expected dot products queued at start and checked at completion.
module tb_dot8_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start8 = 1'b0;
    logic       ready8 = 1'b0;
    logic [2:0] sel8;
    real        a_in8, b_in8, acc8;
    logic       valid8, busy8;
    real        a8[8];
    real        b8[8];

    logic       start3 = 1'b0;
    logic       ready3 = 1'b0;
    logic [2:0] sel3;
    real        a_in3, b_in3, acc3;
    logic       valid3, busy3;
    real        a3[8];
    real        b3[8];

    int  checks = 0;
    int  errors = 0;
    real sb8[$];
    real sb3[$];

    always #5 clk = ~clk;

    // Upstream 8:1 muxes
    always_comb begin
        a_in8 = a8[sel8];
        b_in8 = b8[sel8];
        a_in3 = a3[sel3];
        b_in3 = b3[sel3];
    end

    dot8_sequencer #(.LENGTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .sel       (sel8),
        .a_in      (a_in8),
        .b_in      (b_in8),
        .acc_out   (acc8),
        .out_valid (valid8),
        .out_ready (ready8),
        .busy      (busy8)
    );

    dot8_sequencer #(.LENGTH(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start3),
        .sel       (sel3),
        .a_in      (a_in3),
        .b_in      (b_in3),
        .acc_out   (acc3),
        .out_valid (valid3),
        .out_ready (ready3),
        .busy      (busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8();
        real s;
        s = 0.0;
        for (int i = 0; i < 8; i++) s = s + a8[i] * b8[i];
        sb8.push_back(s);
    endtask

    task automatic push3();
        real s;
        s = 0.0;
        for (int i = 0; i < 3; i++) s = s + a3[i] * b3[i];
        sb3.push_back(s);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) begin
            a8[i] = real'(i + 1);
            b8[i] = 1.0;
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sel8 !== 3'd0) begin
            errors++; $display("FAIL reset_sel: got %0d expected 0", sel8);
        end
        checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got valid=%0b busy=%0b expected 0 0", valid8, busy8);
        end
        checks++;
        if (acc8 != 0.0) begin
            errors++; $display("FAIL reset_acc: got %f expected 0.0", acc8);
        end
        // start held during reset must not take effect
        start8 = 1'b1;
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++; $display("FAIL reset_hold_busy: got %0b expected 0", busy8);
        end
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || sel8 !== 3'd0) begin
            errors++; $display("FAIL idle_no_start: got busy=%0b valid=%0b sel=%0d expected 0 0 0",
                               busy8, valid8, sel8);
        end
    endtask

    task automatic test_basic();
        real exp;
        load_ramp();
        ready8 = 1'b0;
        start8 = 1'b1;
        push8();
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || sel8 !== 3'd0 || valid8 !== 1'b0) begin
            errors++; $display("FAIL basic_enter_run: got busy=%0b sel=%0d valid=%0b expected 1 0 0",
                               busy8, sel8, valid8);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if (sel8 !== 3'(k) || valid8 !== 1'b0) begin
                errors++; $display("FAIL basic_step: got sel=%0d valid=%0b expected sel=%0d valid=0",
                                   sel8, valid8, k);
            end
        end
        tick();
        checks++;
        if (valid8 !== 1'b1 || sel8 !== 3'd0) begin
            errors++; $display("FAIL basic_done: got valid=%0b sel=%0d expected 1 0", valid8, sel8);
        end
        checks++;
        if (sb8.size() == 0) begin
            errors++; $display("FAIL basic_result: got empty scoreboard expected one entry");
        end else begin
            exp = sb8.pop_front();
            if (acc8 != exp) begin
                errors++; $display("FAIL basic_result: got %f expected %f", acc8, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        start8 = 1'b1;
        ready8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (valid8 !== 1'b1 || acc8 != 36.0 || sel8 !== 3'd0 || busy8 !== 1'b1) begin
                errors++; $display("FAIL backpressure_hold: got valid=%0b acc=%f sel=%0d busy=%0b expected 1 36.0 0 1",
                                   valid8, acc8, sel8, busy8);
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        real exp;
        for (int i = 0; i < 8; i++) begin
            a8[i] = 2.0;
            b8[i] = -0.5;
        end
        ready8 = 1'b1;
        start8 = 1'b1;
        push8();
        tick();
        ready8 = 1'b0;
        start8 = 1'b0;
        checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b1 || sel8 !== 3'd0 || acc8 != 36.0) begin
            errors++; $display("FAIL b2b_enter: got valid=%0b busy=%0b sel=%0d acc=%f expected 0 1 0 36.0",
                               valid8, busy8, sel8, acc8);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if (sel8 !== 3'(k) || valid8 !== 1'b0) begin
                errors++; $display("FAIL b2b_step: got sel=%0d valid=%0b expected sel=%0d valid=0",
                                   sel8, valid8, k);
            end
        end
        tick();
        checks++;
        if (valid8 !== 1'b1 || sb8.size() == 0) begin
            errors++; $display("FAIL b2b_done: got valid=%0b queued=%0d expected 1 1", valid8, sb8.size());
        end else begin
            exp = sb8.pop_front();
            if (acc8 != exp) begin
                errors++; $display("FAIL b2b_done: got %f expected %f", acc8, exp);
            end
        end
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || acc8 != -8.0) begin
            errors++; $display("FAIL b2b_release: got busy=%0b valid=%0b acc=%f expected 0 0 -8.0",
                               busy8, valid8, acc8);
        end
    endtask

    task automatic test_mid_reset();
        real exp;
        load_ramp();
        start8 = 1'b1;
        push8();
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        checks++;
        if (sel8 !== 3'd4) begin
            errors++; $display("FAIL midreset_pre: got sel=%0d expected 4", sel8);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sel8 !== 3'd0 || valid8 !== 1'b0 || busy8 !== 1'b0 || acc8 != 0.0) begin
            errors++; $display("FAIL midreset_clear: got sel=%0d valid=%0b busy=%0b acc=%f expected 0 0 0 0.0",
                               sel8, valid8, busy8, acc8);
        end
        sb8.delete();
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b1;
        push8();
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || sel8 !== 3'd0) begin
            errors++; $display("FAIL midreset_restart: got busy=%0b sel=%0d expected 1 0", busy8, sel8);
        end
        repeat (8) tick();
        checks++;
        if (valid8 !== 1'b1 || sb8.size() == 0) begin
            errors++; $display("FAIL midreset_result: got valid=%0b queued=%0d expected 1 1", valid8, sb8.size());
        end else begin
            exp = sb8.pop_front();
            if (acc8 != exp) begin
                errors++; $display("FAIL midreset_result: got %f expected %f", acc8, exp);
            end
        end
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
    endtask

    task automatic test_short_length();
        real exp;
        for (int i = 0; i < 8; i++) begin
            a3[i] = 100.0;
            b3[i] = 100.0;
        end
        a3[0] = 2.0;  b3[0] = 0.5;
        a3[1] = 3.0;  b3[1] = -1.0;
        a3[2] = 4.0;  b3[2] = 2.0;
        start3 = 1'b1;
        push3();
        tick();
        start3 = 1'b0;
        checks++;
        if (busy3 !== 1'b1 || sel3 !== 3'd0) begin
            errors++; $display("FAIL short_enter: got busy=%0b sel=%0d expected 1 0", busy3, sel3);
        end
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if (sel3 !== 3'(k) || valid3 !== 1'b0) begin
                errors++; $display("FAIL short_step: got sel=%0d valid=%0b expected sel=%0d valid=0",
                                   sel3, valid3, k);
            end
        end
        tick();
        checks++;
        if (valid3 !== 1'b1 || sel3 !== 3'd0 || sb3.size() == 0) begin
            errors++; $display("FAIL short_done: got valid=%0b sel=%0d queued=%0d expected 1 0 1",
                               valid3, sel3, sb3.size());
        end else begin
            exp = sb3.pop_front();
            if (acc3 != exp) begin
                errors++; $display("FAIL short_result: got %f expected %f", acc3, exp);
            end
        end
        ready3 = 1'b1;
        tick();
        ready3 = 1'b0;
        checks++;
        if (busy3 !== 1'b0 || valid3 !== 1'b0 || acc3 != 6.0) begin
            errors++; $display("FAIL short_release: got busy=%0b valid=%0b acc=%f expected 0 0 6.0",
                               busy3, valid3, acc3);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            a8[i] = 0.0; b8[i] = 0.0;
            a3[i] = 0.0; b3[i] = 0.0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_short_length();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
